// File: rtl/aes_inv_cipher_iter_if.sv
// aes_inv_cipher_iter_if: load/result handshake bundle for the iterative AES-128 decryption core.
interface aes_inv_cipher_iter_if;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] ct, key, pt;
  modport master(output in_valid, ct, key, out_ready, input in_ready, out_valid, pt, busy);
  modport slave(input in_valid, ct, key, out_ready, output in_ready, out_valid, pt, busy);
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES-128 decryption, one inverse round per clock with backward key schedule.
package aes_gf_pkg;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, r;
    p = a;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= p;
      p = xt(p);
    end
    return r;
  endfunction
  // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction
  function automatic logic [7:0] mulc(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction
  function automatic logic [31:0] imc_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {mulc(a0, 4'he) ^ mulc(a1, 4'hb) ^ mulc(a2, 4'hd) ^ mulc(a3, 4'h9),
            mulc(a0, 4'h9) ^ mulc(a1, 4'he) ^ mulc(a2, 4'hb) ^ mulc(a3, 4'hd),
            mulc(a0, 4'hd) ^ mulc(a1, 4'h9) ^ mulc(a2, 4'he) ^ mulc(a3, 4'hb),
            mulc(a0, 4'hb) ^ mulc(a1, 4'hd) ^ mulc(a2, 4'h9) ^ mulc(a3, 4'he)};
  endfunction
endpackage

module sbox
  import aes_gf_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);
  logic [7:0] b;
  assign b = gf_inv(a);
  assign s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
endmodule

module inv_sbox
  import aes_gf_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);
  logic [7:0] y;
  assign y = rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
  assign s = gf_inv(y);
endmodule

module rcon (
  input  logic [3:0] i,
  output logic [7:0] r
);
  localparam logic [127:0] T = 128'h0001020408102040801b360000000000;
  assign r = T[{~i, 3'b111} -: 8];
endmodule

module aes_inv_cipher_iter
  import aes_gf_pkg::*;
#(
  parameter int NR = 10
) (
  input logic clk,
  input logic reset,
  aes_inv_cipher_iter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_ROUND = 2'd1, S_DONE = 2'd2;
  logic [1:0] state;
  logic [3:0] rnd;
  logic [127:0] st, rk, rk_next, sb, t, mc, pt;
  logic [31:0] w0n, w1n, w2n, w3n, rot, sw;
  logic [7:0] rc;
  logic out_valid;
  assign w3n = rk[31:0] ^ rk[63:32];
  assign w2n = rk[63:32] ^ rk[95:64];
  assign w1n = rk[95:64] ^ rk[127:96];
  assign rot = {w3n[23:0], w3n[31:24]};
  for (genvar j = 0; j < 4; j++) begin : g_sw
    sbox u_sbox (.a(rot[8*j +: 8]), .s(sw[8*j +: 8]));
  end
  rcon u_rcon (.i(rnd + 4'd1), .r(rc));
  assign w0n = rk[127:96] ^ sw ^ {rc, 24'h0};
  assign rk_next = {w0n, w1n, w2n, w3n};
  // byte i sits at row i%4, column i/4; InvShiftRows pulls row r from column c-r
  for (genvar i = 0; i < 16; i++) begin : g_isb
    localparam int S = (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4);
    inv_sbox u_inv_sbox (.a(st[127-8*S -: 8]), .s(sb[127-8*i -: 8]));
  end
  assign t = sb ^ rk_next;
  assign mc = {imc_col(t[127:96]), imc_col(t[95:64]), imc_col(t[63:32]), imc_col(t[31:0])};
  assign bus.in_ready = state == S_IDLE;
  assign bus.busy = state == S_ROUND;
  assign bus.out_valid = out_valid;
  assign bus.pt = pt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      rnd <= 4'd0;
      st <= '0;
      rk <= '0;
      pt <= '0;
      out_valid <= 1'b0;
    end else if (state == S_IDLE && bus.in_valid) begin
      st <= bus.ct ^ bus.key;
      rk <= bus.key;
      rnd <= 4'(NR - 1);
      state <= S_ROUND;
    end else if (state == S_ROUND) begin
      st <= rnd != 4'd0 ? mc : t;
      rk <= rk_next;
      if (rnd == 4'd0) begin
        pt <= t;
        out_valid <= 1'b1;
        state <= S_DONE;
      end else rnd <= rnd - 4'd1;
    end else if (state == S_DONE && bus.out_ready) begin
      out_valid <= 1'b0;
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter: directed FIPS-197 vectors against the iterative decryption core.
module tb_aes_inv_cipher_iter;
  localparam logic [127:0] K1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  aes_inv_cipher_iter_if bus ();
  aes_inv_cipher_iter #(.NR(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [127:0] c, input logic [127:0] k,
                     input logic [127:0] p, input bit scramble);
    int lat;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.ct = c;
    bus.key = k;
    check({tag, "_rdy"}, 128'(bus.in_ready), 128'd1);
    tick();
    bus.in_valid = 1'b0;
    if (scramble) begin
      bus.ct = {$urandom, $urandom, $urandom, $urandom};
      bus.key = {$urandom, $urandom, $urandom, $urandom};
    end
    check({tag, "_busy"}, 128'(bus.busy), 128'd1);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'd10);
    check({tag, "_pt"}, bus.pt, p);
    tick();
    check({tag, "_ov_drop"}, 128'(bus.out_valid), 128'd0);
  endtask

  initial begin
    bit held;
    int acc[2];
    logic [127:0] pts[2];
    int na, np;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.ct = '0;
    bus.key = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_pt", bus.pt, 128'd0);
    tick();
    reset = 1'b0;
    tick();
    run("c1", C1, K1, P1, 1'b0);
    run("appb", C2, K2, P2, 1'b0);
    // result held under backpressure, stray request ignored
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.ct = C1;
    bus.key = K1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 30 && !bus.out_valid; i++) tick();
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.ct = C2;
      bus.key = K2;
      if (!(bus.out_valid && bus.pt == P1 && !bus.in_ready && !bus.busy)) held = 1'b0;
      tick();
    end
    check("stall_held", 128'(held), 128'd1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("stall_ov_drop", 128'(bus.out_valid), 128'd0);
    check("stall_rdy_after", 128'(bus.in_ready), 128'd1);
    check("stall_pt_kept", bus.pt, P1);
    tick();
    check("stall_no_accept", 128'(bus.busy), 128'd0);
    // back-to-back with in_valid held high
    na = 0;
    np = 0;
    bus.ct = C1;
    bus.key = K1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.in_ready && na < 2) begin
        acc[na] = i;
        na++;
      end
      if (bus.out_valid && np < 2) begin
        pts[np] = bus.pt;
        np++;
      end
      tick();
      if (na == 1) begin
        bus.ct = C2;
        bus.key = K2;
      end
      if (na == 2) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    check("b2b_count", 128'({na[7:0], np[7:0]}), 128'h0202);
    check("b2b_ii", 128'(acc[1] - acc[0]), 128'd12);
    check("b2b_pt0", pts[0], P1);
    check("b2b_pt1", pts[1], P2);
    // reset while rnd = 5
    bus.in_valid = 1'b1;
    bus.ct = C1;
    bus.key = K1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    #1;
    check("mid_in_ready", 128'(bus.in_ready), 128'd1);
    check("mid_out_valid", 128'(bus.out_valid), 128'd0);
    check("mid_busy", 128'(bus.busy), 128'd0);
    check("mid_pt", bus.pt, 128'd0);
    reset = 1'b0;
    tick();
    run("post_rst", C1, K1, P1, 1'b0);
    run("scramble", C2, K2, P2, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
